// File: rtl/mem_access_ctrl.sv
// Memory access controller: single outstanding load/store to a word-wide RAM
// with Enable/MOV/MOC handshake, sub-word read-modify-write and load extension.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        Enable,
  output logic        MOV,
  output logic        RW,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic        MOC
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_MERGE,
    S_ABORT
  } state_t;

  state_t state, state_nx;

  logic          l_rw;
  logic [1:0]    l_size;
  logic          l_sign;
  logic [8:0]    l_addr;
  logic [31:0]   l_wdata;
  logic [31:0]   wword;
  logic [31:0]   cap;
  logic          rmw_rd;
  logic          first_rel;
  logic [CW-1:0] cnt;
  logic          rw_eff;
  logic          misal;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b10 && off != 2'b00);
  endfunction

  // Big-endian lane select: offset 0 is the most significant byte/halfword.
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_splice(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0]  = d[15:0];
        else        r[31:16] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign misal    = misaligned(size, addr[1:0]);
  assign rw_eff   = l_rw | rmw_rd;
  assign ram_addr = {1'b0, l_addr[8:2]};
  assign ram_din  = wword;

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    Enable   = 1'b0;
    MOV      = 1'b0;
    RW       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) state_nx = misal ? S_ABORT : S_SETUP;
      end
      S_SETUP: begin
        Enable   = 1'b1;
        RW       = rw_eff;
        state_nx = S_STROBE;
      end
      S_STROBE: begin
        Enable = 1'b1;
        MOV    = 1'b1;
        RW     = rw_eff;
        if (MOC)                         state_nx = S_RELEASE;
        else if (cnt == CW'(TIMEOUT - 1)) state_nx = S_ABORT;
      end
      S_RELEASE: begin
        done = first_rel & ~rmw_rd;
        if (!MOC) state_nx = rmw_rd ? S_MERGE : S_IDLE;
      end
      S_MERGE: begin
        state_nx = S_SETUP;
      end
      S_ABORT: begin
        done     = 1'b1;
        err      = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      l_rw      <= 1'b0;
      l_size    <= '0;
      l_sign    <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
      wword     <= '0;
      cap       <= '0;
      rmw_rd    <= 1'b0;
      first_rel <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (req) begin
            l_rw    <= rw;
            l_size  <= size;
            l_sign  <= sign;
            l_addr  <= addr;
            l_wdata <= wdata;
            wword   <= wdata;
            // Sub-word stores begin with the read half of a read-modify-write.
            rmw_rd  <= ~rw & (size != 2'b10);
            cnt     <= '0;
          end
        end
        S_SETUP: cnt <= '0;
        S_STROBE: begin
          if (MOC) begin
            first_rel <= 1'b1;
            if (l_rw)        rdata <= lane_extract(ram_dout, l_size, l_addr[1:0], l_sign);
            else if (rmw_rd) cap   <= ram_dout;
          end else if (cnt != CW'(TIMEOUT - 1)) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RELEASE: first_rel <= 1'b0;
        S_MERGE: begin
          wword  <= lane_splice(cap, l_wdata, l_size, l_addr[1:0]);
          rmw_rd <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
